operand_fetch_ctrl: RTL and testbench
=====================================

// Module: operand_fetch_ctrl
// PURPOSE
//  Sequences operand fetch for one instruction word ahead of the operand/address mux stage.
//  Opcode bits IMM1_BIT/IMM2_BIT select, per operand, an immediate or a register-file read.
//  Register reads go over a single read port that is shared with other requesters via a req/gnt arbiter.
//  Each non-immediate operand is read in turn; both operands are then presented with a valid/ready handshake.
// PARAMETERS
//  DATA_W    32  width of operands, addresses and opcode
//  IMM1_BIT  28  opcode bit: 1 = operand A from imm_1, 0 = read reg at addr_1
//  IMM2_BIT  29  opcode bit: 1 = operand B from imm_2, 0 = read reg at addr_2
//  STALL_W   16  width of the saturating stall counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  in_valid   in   1       instruction fields valid
//  in_ready   out  1       block accepts an instruction
//  op_code    in   DATA_W  instruction opcode word
//  addr_1     in   DATA_W  operand A register address
//  addr_2     in   DATA_W  operand B register address
//  imm_1      in   DATA_W  operand A immediate
//  imm_2      in   DATA_W  operand B immediate
//  rd_req     out  1       register read-port request
//  rd_addr    out  DATA_W  read address, stable while rd_req=1
//  rd_gnt     in   1       arbiter grant; read is issued in the cycle with rd_req & rd_gnt
//  rd_data    in   DATA_W  read data, valid exactly 1 cycle after the grant cycle
//  out_valid  out  1       opa/opb/out_op valid
//  out_ready  in   1       downstream accepts
//  opa        out  DATA_W  operand A
//  opb        out  DATA_W  operand B
//  out_op     out  DATA_W  captured opcode
//  clr_stats  in   1       synchronous clear of stall_cnt
//  stall_cnt  out  STALL_W cycles with rd_req=1 & rd_gnt=0, saturating at all-ones
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; in_ready=1; rd_req, out_valid=0; rd_addr, opa, opb, out_op, stall_cnt=0.
//    Reset mid-fetch abandons the fetch; rd_req drops without waiting for a clock edge.
//  - FSM states: IDLE, REQ_A, DAT_A, REQ_B, DAT_B, DONE. in_ready = (state==IDLE).
//  - IDLE: on in_valid, capture all inputs. Next state is:
//      REQ_A if operand A is a register;
//      else REQ_B if operand B is a register;
//      else DONE (opa=imm_1, opb=imm_2).
//    Immediate operands are written to opa/opb at capture.
//  - REQ_x: rd_req=1, rd_addr=captured addr_x. On rd_gnt go to DAT_x; otherwise hold and increment stall_cnt.
//  - DAT_A: opa<=rd_data. Next state is REQ_B if B is a register and addr_2!=addr_1; otherwise DONE.
//    If B is a register and addr_2==addr_1, also opb<=rd_data (single shared read).
//  - DAT_B: opb<=rd_data; next state DONE.
//  - DONE: out_valid=1; opa/opb/out_op held stable. On out_ready, go to IDLE. No back-to-back accept in the same cycle.
//  - Latency from accept to out_valid:
//      both immediates: 1 cycle;
//      one register read with immediate grant: 3 cycles;
//      two register reads: 5 cycles; plus one cycle per denied request.
//  - clr_stats has priority over increment. The counter does not wrap.
//  - Only opcode bits IMM1_BIT/IMM2_BIT are decoded; the opcode word passes through untouched.
// STRUCTURE
//  - Shared package: FSM state enum (fetch_state_t), default IMM1_BIT/IMM2_BIT constants (shared with the operand mux).
//  - One sub-module: sat_counter (STALL_W, inc, clr) for stall_cnt. FSM and datapath registers stay inline.
// TESTING
//  1. op_code=32'h3000_0000, imm_1=5, imm_2=7, out_ready=1:
//     -> out_valid 1 cycle after accept; opa=5, opb=7; rd_req never asserted.
//  2. op_code=0, addr_1=3, addr_2=4, rd_gnt tied 1, regfile r3=0xAA, r4=0xBB:
//     -> two reads; opa=0xAA, opb=0xBB; out_valid 5 cycles after accept.
//  3. op_code=0, addr_1=addr_2=9, r9=0x55:
//     -> exactly one grant; opa=opb=0x55; out_valid 3 cycles after accept.
//  4. op_code=32'h1000_0000, addr_2=2, rd_gnt held low 4 cycles:
//     -> rd_addr=2 stable throughout; stall_cnt=4; opa=imm_1; then clr_stats -> stall_cnt=0.
//  5. out_ready low 3 cycles in DONE:
//     -> out_valid, opa, opb stable and in_ready=0; accept resumes the cycle after out_ready.
//  6. rst pulsed low while in REQ_B:
//     -> rd_req=0 immediately; all outputs 0; the next instruction fetches cleanly.

Source files
------------

// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the operand fetch controller and the operand mux that follows it.
// Holds the fetch FSM encoding and the default opcode bit positions of the immediate selects.
package operand_fetch_ctrl_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int IMM1_BIT_DEF = 28;
    localparam int IMM2_BIT_DEF = 29;
    localparam int STALL_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ_A = 3'd1,
        DAT_A = 3'd2,
        REQ_B = 3'd3,
        DAT_B = 3'd4,
        DONE  = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/operand_fetch_ctrl_if.sv
// Instruction-in, shared register read port and operand-out signals of the fetch controller.
// The slave modport is the controller's view; master is the surrounding pipeline and arbiter.
interface operand_fetch_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_code;
    logic [DATA_W-1:0] addr_1;
    logic [DATA_W-1:0] addr_2;
    logic [DATA_W-1:0] imm_1;
    logic [DATA_W-1:0] imm_2;

    logic              rd_req;
    logic [DATA_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] out_op;

    modport slave (
        input  in_valid, op_code, addr_1, addr_2, imm_1, imm_2,
        input  rd_gnt, rd_data, out_ready,
        output in_ready, rd_req, rd_addr, out_valid, opa, opb, out_op
    );

    modport master (
        output in_valid, op_code, addr_1, addr_2, imm_1, imm_2,
        output rd_gnt, rd_data, out_ready,
        input  in_ready, rd_req, rd_addr, out_valid, opa, opb, out_op
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Fetches operands A and B for one instruction, each from its immediate or from the shared
// register read port, then holds them with the opcode until the downstream stage accepts.
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IMM1_BIT = IMM1_BIT_DEF,
    parameter int IMM2_BIT = IMM2_BIT_DEF,
    parameter int STALL_W  = STALL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    operand_fetch_ctrl_if.slave bus,
    input  logic               clr_stats,
    output logic [STALL_W-1:0] stall_cnt
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;

    logic [DATA_W-1:0] op_reg;
    logic [DATA_W-1:0] addr1_reg;
    logic [DATA_W-1:0] addr2_reg;
    logic [DATA_W-1:0] opa_reg;
    logic [DATA_W-1:0] opb_reg;

    logic              rd_req_next;
    logic [DATA_W-1:0] rd_addr_next;

    logic              in_a_imm;
    logic              in_b_imm;
    logic              b_is_reg;
    logic              same_addr;

    assign in_a_imm  = bus.op_code[IMM1_BIT];
    assign in_b_imm  = bus.op_code[IMM2_BIT];
    assign b_is_reg  = !op_reg[IMM2_BIT];
    assign same_addr = (addr1_reg == addr2_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_req_next  = 1'b0;
        rd_addr_next = '0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!in_a_imm) begin
                        state_next = REQ_A;
                    end else if (!in_b_imm) begin
                        state_next = REQ_B;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            REQ_A: begin
                rd_req_next  = 1'b1;
                rd_addr_next = addr1_reg;
                if (bus.rd_gnt) begin
                    state_next = DAT_A;
                end
            end
            DAT_A: begin
                // A matching B address reuses the read just returned for A.
                state_next = (b_is_reg && !same_addr) ? REQ_B : DONE;
            end
            REQ_B: begin
                rd_req_next  = 1'b1;
                rd_addr_next = addr2_reg;
                if (bus.rd_gnt) begin
                    state_next = DAT_B;
                end
            end
            DAT_B: begin
                state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg    <= '0;
            addr1_reg <= '0;
            addr2_reg <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg    <= bus.op_code;
                        addr1_reg <= bus.addr_1;
                        addr2_reg <= bus.addr_2;
                        if (in_a_imm) begin
                            opa_reg <= bus.imm_1;
                        end
                        if (in_b_imm) begin
                            opb_reg <= bus.imm_2;
                        end
                    end
                end
                DAT_A: begin
                    opa_reg <= bus.rd_data;
                    if (b_is_reg && same_addr) begin
                        opb_reg <= bus.rd_data;
                    end
                end
                DAT_B: begin
                    opb_reg <= bus.rd_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Request outputs decode straight from state so an async reset drops them at once.
    assign bus.rd_req    = rd_req_next;
    assign bus.rd_addr   = rd_addr_next;
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.opa       = opa_reg;
    assign bus.opb       = opb_reg;
    assign bus.out_op    = op_reg;

    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rd_req_next && !bus.rd_gnt),
        .clr (clr_stats),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Scoreboarded bench: stimulus queues expected operands and read addresses; a negedge
// environment process plays arbiter, register file and consumer, and checks every output.
module tb_operand_fetch_ctrl;

    localparam int DW = 32;
    localparam int SW = 4;

    typedef struct {
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [DW-1:0] op;
        int            nreads;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr_stats = 1'b0;
    logic [SW-1:0] stall_cnt;

    operand_fetch_ctrl_if #(.DATA_W(DW)) bus ();

    operand_fetch_ctrl #(
        .DATA_W  (DW),
        .STALL_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_stats (clr_stats),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] regfile [16];
    exp_t          exp_q [$];
    logic [DW-1:0] addr_q [$];

    // Environment knobs set by stimulus.
    bit gnt_mode   = 1'b1;
    bit ready_mode = 1'b1;
    int deny_left  = 0;
    int ready_hold = 0;

    // Environment state.
    int            cyc = 0;
    int            acc_cyc = 0;
    int            grants = 0;
    int            denials = 0;
    bit            busy = 1'b0;
    bit            seen = 1'b0;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_addr = '0;
    logic [SW-1:0] stall_model = '0;
    exp_t          pop_e;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            addr_q.delete();
            busy        = 1'b0;
            seen        = 1'b0;
            pend        = 1'b0;
            stall_model = '0;
            bus.rd_gnt    = 1'b0;
            bus.out_ready = 1'b0;
            bus.rd_data   = '0;
        end else begin
            // Read data appears only in the cycle after a grant; junk otherwise.
            bus.rd_data = pend ? regfile[pend_addr[3:0]] : DW'($urandom);
            chk("in_ready", DW'(bus.in_ready), DW'(!busy));
            chk("stall_cnt", DW'(stall_cnt), DW'(stall_model));

            if (bus.rd_req && deny_left > 0) begin
                bus.rd_gnt = 1'b0;
                deny_left--;
            end else if (gnt_mode) begin
                bus.rd_gnt = 1'b1;
            end else begin
                bus.rd_gnt = ($urandom_range(0, 9) < 6);
            end
            if (bus.out_valid && ready_hold > 0) begin
                bus.out_ready = 1'b0;
                ready_hold--;
            end else if (ready_mode) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = ($urandom_range(0, 9) < 7);
            end

            pend      = bus.rd_req && bus.rd_gnt;
            pend_addr = bus.rd_addr;

            if (bus.rd_req) begin
                if (!busy || addr_q.size() == 0) begin
                    fail_now("rd_req", "asserted with no read expected");
                end else begin
                    chk("rd_addr", bus.rd_addr, addr_q[0]);
                    if (bus.rd_gnt) begin
                        void'(addr_q.pop_front());
                        grants++;
                    end else begin
                        denials++;
                    end
                end
            end

            if (clr_stats) begin
                stall_model = '0;
            end else if (bus.rd_req && !bus.rd_gnt && stall_model != {SW{1'b1}}) begin
                stall_model = stall_model + 1'b1;
            end

            if (bus.in_valid && bus.in_ready) begin
                busy    = 1'b1;
                seen    = 1'b0;
                acc_cyc = cyc;
                grants  = 0;
                denials = 0;
            end

            if (bus.out_valid) begin
                if (!busy || exp_q.size() == 0) begin
                    fail_now("out_valid", "asserted with no transaction outstanding");
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", DW'(cyc - acc_cyc), DW'(1 + 2 * exp_q[0].nreads + denials));
                    end
                    if (bus.out_ready) begin
                        pop_e = exp_q.pop_front();
                        chk("opa", bus.opa, pop_e.opa);
                        chk("opb", bus.opb, pop_e.opb);
                        chk("out_op", bus.out_op, pop_e.op);
                        chk("reads", DW'(grants), DW'(pop_e.nreads));
                        $display("txn op=%h opa=%h opb=%h reads=%0d denied=%0d lat=%0d",
                                 bus.out_op, bus.opa, bus.opb, grants, denials, cyc - acc_cyc);
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            fail_now("accept", "in_ready not seen within 300 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            fail_now("drain", "transaction not completed within 400 cycles");
        end
    endtask

    task automatic issue(input logic [DW-1:0] op, input logic [DW-1:0] a1,
                         input logic [DW-1:0] a2, input logic [DW-1:0] i1,
                         input logic [DW-1:0] i2);
        exp_t e;
        bit   ar;
        bit   br;
        ar       = !op[28];
        br       = !op[29];
        e.op     = op;
        e.opa    = ar ? regfile[a1[3:0]] : i1;
        e.opb    = br ? regfile[a2[3:0]] : i2;
        e.nreads = 0;
        if (ar) begin
            addr_q.push_back(a1);
            e.nreads++;
        end
        if (br && !(ar && a1 == a2)) begin
            addr_q.push_back(a2);
            e.nreads++;
        end
        exp_q.push_back(e);
        bus.op_code  = op;
        bus.addr_1   = a1;
        bus.addr_2   = a2;
        bus.imm_1    = i1;
        bus.imm_2    = i2;
        bus.in_valid = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        bus.op_code  = DW'($urandom);
        bus.addr_1   = DW'($urandom);
        bus.addr_2   = DW'($urandom);
        bus.imm_1    = DW'($urandom);
        bus.imm_2    = DW'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] op;
        logic [DW-1:0] a1;
        logic [DW-1:0] a2;
        for (int i = 0; i < 16; i++) begin
            regfile[i] = DW'($urandom);
        end
        regfile[3] = 32'hAA;
        regfile[4] = 32'hBB;
        regfile[9] = 32'h55;
        bus.in_valid = 1'b0;
        bus.op_code  = '0;
        bus.addr_1   = '0;
        bus.addr_2   = '0;
        bus.imm_1    = '0;
        bus.imm_2    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", DW'(bus.in_ready), 32'd1);
        chk("rst_rd_req", DW'(bus.rd_req), 32'd0);
        chk("rst_out_valid", DW'(bus.out_valid), 32'd0);
        chk("rst_rd_addr", bus.rd_addr, 32'd0);
        chk("rst_opa", bus.opa, 32'd0);
        chk("rst_opb", bus.opb, 32'd0);
        chk("rst_out_op", bus.out_op, 32'd0);
        chk("rst_stall", DW'(stall_cnt), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Both immediates, two reads, one shared read.
        issue(32'h3000_0000, 32'd0, 32'd0, 32'd5, 32'd7);
        wait_idle();
        issue(32'h0000_0000, 32'd3, 32'd4, 32'h1111, 32'h2222);
        wait_idle();
        issue(32'h0000_0000, 32'd9, 32'd9, 32'h3333, 32'h4444);
        wait_idle();

        // Four denied requests on operand B, then clear the statistic.
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        deny_left = 4;
        issue(32'h1000_0000, 32'd6, 32'd2, 32'hC0DE, 32'h9999);
        wait_idle();
        chk("stall_after_denials", DW'(stall_cnt), 32'd4);
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        chk("stall_after_clr", DW'(stall_cnt), 32'd0);

        // Downstream back-pressure for three cycles, then a follow-on instruction.
        ready_hold = 3;
        issue(32'h3000_00A5, 32'd1, 32'd2, 32'hDEAD, 32'hBEEF);
        issue(32'h2000_0000, 32'd5, 32'd0, 32'h7777, 32'h8888);
        wait_idle();

        // Asynchronous reset while operand B is being requested.
        bus.op_code  = 32'h1000_0000;
        bus.addr_1   = 32'd1;
        bus.addr_2   = 32'd2;
        bus.imm_1    = 32'h1234;
        bus.imm_2    = 32'h5678;
        bus.in_valid = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        chk("reqb_rd_req", DW'(bus.rd_req), 32'd1);
        chk("reqb_rd_addr", bus.rd_addr, 32'd2);
        chk("reqb_opa", bus.opa, 32'h1234);
        rst = 1'b0;
        #1;
        chk("arst_rd_req", DW'(bus.rd_req), 32'd0);
        chk("arst_rd_addr", bus.rd_addr, 32'd0);
        chk("arst_in_ready", DW'(bus.in_ready), 32'd1);
        chk("arst_out_valid", DW'(bus.out_valid), 32'd0);
        chk("arst_opa", bus.opa, 32'd0);
        chk("arst_opb", bus.opb, 32'd0);
        chk("arst_out_op", bus.out_op, 32'd0);
        chk("arst_stall", DW'(stall_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h0000_0000, 32'd3, 32'd4, 32'h0, 32'h0);
        wait_idle();

        // Random traffic with random grants, back-pressure and occasional clears.
        gnt_mode   = 1'b0;
        ready_mode = 1'b0;
        for (int n = 0; n < 200; n++) begin
            op     = DW'($urandom);
            op[28] = 1'($urandom_range(0, 1));
            op[29] = 1'($urandom_range(0, 1));
            a1     = DW'($urandom_range(0, 15));
            a2     = ($urandom_range(0, 3) == 0) ? a1 : DW'($urandom_range(0, 15));
            clr_stats = ($urandom_range(0, 15) == 0);
            issue(op, a1, a2, DW'($urandom), DW'($urandom));
            clr_stats = 1'b0;
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
